// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: data width, default FIFO depth
// and the occupancy-counter width helper.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int FIFO_DEPTH_DEFAULT = 16;

    // Occupancy must represent 0..depth inclusive, hence one bit more than the pointer.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int FIFO_COUNT_W = count_width(FIFO_DEPTH_DEFAULT);

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x UART_DATA_W register-array storage with one synchronous write port
// and one asynchronous read port; contents are never reset.
module sync_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [UART_DATA_W-1:0]   wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [UART_DATA_W-1:0]   rd_data
);

    logic [UART_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: one capture per in_done rise, show-ahead
// FIFO with valid/ready read side and sticky overflow. Define UART_RX_FIFO_AFULL_EN for rx_afull.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = FIFO_DEPTH_DEFAULT,
    parameter int AFULL_THRESH = 12
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic [UART_DATA_W-1:0]        in_data,
    input  logic                          in_done,
    output logic [UART_DATA_W-1:0]        rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [count_width(DEPTH)-1:0] rx_count,
    output logic                          rx_overflow,
    input  logic                          ovf_clr
`ifdef UART_RX_FIFO_AFULL_EN
    ,
    output logic                          rx_afull
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    // Reject configurations the pointer arithmetic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("uart_rx_fifo: AFULL_THRESH must be in 1..DEPTH");
    end

    logic          done_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push_req;
    logic          full;
    logic          pop;
    logic          do_push;
    logic          drop;

    assign push_req = in_done & ~done_q;
    assign full     = (count == FULL_LVL);
    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    assign do_push  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign rx_count = count;

    sync_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_comb begin
        count_next = count;
        case ({do_push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // done_q resets high so a frame already in its stop bit at release is not captured.
    always_ff @(posedge clk) begin
        if (areset) begin
            done_q      <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_overflow <= 1'b0;
        end else begin
            done_q <= in_done;
            count  <= count_next;
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop) begin
                rx_overflow <= 1'b1;
            end else if (ovf_clr) begin
                rx_overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_AFULL_EN
    always_ff @(posedge clk) begin
        if (areset) begin
            rx_afull <= 1'b0;
        end else begin
            rx_afull <= (count_next >= CW'(AFULL_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a negedge
// monitor pops and compares every accepted read. Define UART_RX_FIFO_AFULL_EN to cover rx_afull.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       areset;
    logic [7:0] in_data;
    logic       in_done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] rx_count;
    logic       rx_overflow;
    logic       ovf_clr;
`ifdef UART_RX_FIFO_AFULL_EN
    logic       rx_afull;
`endif

    logic [7:0] exp_q [$];
    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH        (16),
        .AFULL_THRESH (12)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .in_data     (in_data),
        .in_done     (in_done),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rx_count    (rx_count),
        .rx_overflow (rx_overflow),
        .ovf_clr     (ovf_clr)
`ifdef UART_RX_FIFO_AFULL_EN
        ,
        .rx_afull    (rx_afull)
`endif
    );

    // Monitor: a handshake seen at the negedge becomes a pop at the next posedge.
    always @(negedge clk) begin
        if (!areset && rd_valid && rd_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("[TB] FAIL read_unexpected: got %02h, expected nothing", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_miss++;
                    $display("[TB] FAIL read_data: got %02h, expected %02h", rd_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // One receiver frame: in_done held for hold cycles, then one idle cycle.
    task automatic send_frame(input logic [7:0] b, input int hold);
        in_data = b;
        in_done = 1'b1;
        repeat (hold) tick();
        in_done = 1'b0;
        in_data = 8'h00;
        tick();
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        areset   = 1'b1;
        in_data  = 8'h00;
        in_done  = 1'b0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        tick();
        tick();
        check("reset_count", int'(rx_count), 0);
        check("reset_valid", int'(rd_valid), 0);
        check("reset_ovf", int'(rx_overflow), 0);
        areset = 1'b0;
        tick();

        // Single long frame: one capture, valid the cycle after the rise.
        in_data = 8'hA5;
        in_done = 1'b1;
        check("no_bypass_valid", int'(rd_valid), 0);
        tick();
        check("one_frame_valid", int'(rd_valid), 1);
        check("one_frame_data", int'(rd_data), 8'hA5);
        check("one_frame_count", int'(rx_count), 1);
        repeat (19) tick();
        check("long_done_count", int'(rx_count), 1);
        in_done = 1'b0;
        in_data = 8'h00;
        tick();
        exp_q.push_back(8'hA5);
        drain(1);
        check("after_a5_count", int'(rx_count), 0);

        // Three frames, then back-to-back reads and an extra read on empty.
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 3);
        end
        check("three_count", int'(rx_count), 3);
        rd_ready = 1'b1;
        tick();
        check("pop1_count", int'(rx_count), 2);
        tick();
        check("pop2_count", int'(rx_count), 1);
        tick();
        check("pop3_count", int'(rx_count), 0);
        check("pop3_valid", int'(rd_valid), 0);
        tick();
        tick();
        check("empty_ready_count", int'(rx_count), 0);
        rd_ready = 1'b0;

        // Overflow: 17 frames into 16 entries, then clear/priority checks.
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 2);
        end
        check("full_count", int'(rx_count), 16);
        check("full_ovf", int'(rx_overflow), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(rx_overflow), 0);
        in_data = 8'h11;
        in_done = 1'b1;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_set_priority", int'(rx_overflow), 1);
        check("drop_count", int'(rx_count), 16);
        in_done = 1'b0;
        in_data = 8'h00;
        tick();
        drain(16);
        check("drain_count", int'(rx_count), 0);
        check("ovf_sticky", int'(rx_overflow), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clear2", int'(rx_overflow), 0);

        // Full with simultaneous push and pop: no overflow, 5A lands last.
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h20 + 8'(i));
            send_frame(8'h20 + 8'(i), 2);
        end
        check("refill_count", int'(rx_count), 16);
        exp_q.push_back(8'h5A);
        in_data  = 8'h5A;
        in_done  = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("pushpop_count", int'(rx_count), 16);
        check("pushpop_ovf", int'(rx_overflow), 0);
        in_done = 1'b0;
        in_data = 8'h00;
        tick();
        drain(16);
        check("drain2_count", int'(rx_count), 0);

        // Reset mid-operation with in_done high.
        for (int i = 0; i < 4; i++) send_frame(8'h40 + 8'(i), 2);
        check("pre_reset_count", int'(rx_count), 4);
        in_data = 8'h99;
        in_done = 1'b1;
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        repeat (5) tick();
        check("post_reset_count", int'(rx_count), 0);
        check("post_reset_valid", int'(rd_valid), 0);
        in_done = 1'b0;
        in_data = 8'h00;
        tick();
        check("post_reset_fall", int'(rx_count), 0);
        exp_q.push_back(8'h77);
        send_frame(8'h77, 2);
        check("post_reset_new", int'(rx_count), 1);
        drain(1);

`ifdef UART_RX_FIFO_AFULL_EN
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(8'h60 + 8'(i));
            send_frame(8'h60 + 8'(i), 2);
        end
        check("afull_below", int'(rx_afull), 0);
        exp_q.push_back(8'h6B);
        in_data = 8'h6B;
        in_done = 1'b1;
        tick();
        check("afull_count12", int'(rx_count), 12);
        check("afull_set", int'(rx_afull), 1);
        in_done = 1'b0;
        in_data = 8'h00;
        tick();
        drain(1);
        check("afull_clear", int'(rx_afull), 0);
        drain(11);
`endif

        tick();
        check("final_count", int'(rx_count), 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
